pc_unit: RTL and testbench
==========================

# pc_unit

Registered program-counter unit for the fetch stage, replacing the purely combinational next-PC calculation. Holds the PC in a register, advances it by a configurable increment, applies sign-extended and shifted branch offsets, and services subroutine calls and returns through an optional circular return-address stack (RAS). The unit sits between decode/control, which supplies the branch and return requests, and instruction memory, which consumes `pc`.

## Interface
Parameters:
- `ADDR_W`, 32: PC width.
- `OFFSET_W`, 24: width of the branch offset field.
- `OFFSET_SHIFT`, 2: left shift applied after sign extension.
- `PC_INCR`, 4: sequential increment.
- `RESET_VEC`, 0: PC value after reset.
- `RAS_DEPTH`, 4: number of RAS entries, a power of two ≥ 2.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold the PC and RAS.
- `branch` in 1: take the branch to `pc + (sext(offset) << OFFSET_SHIFT)`.
- `link` in 1: qualifies `branch`; also push the return address.
- `ret` in 1: take the return.
- `offset` in OFFSET_W: branch offset field.
- `ret_addr` in ADDR_W: architectural link-register value, used as the fallback return target.
- `pc` out ADDR_W: current PC (registered).
- `ras_hit` out 1: registered; the last accepted `ret` used the RAS.
- `ras_count` out clog2(RAS_DEPTH)+1: number of valid RAS entries.
- `ras_ovf` out 1: sticky flag, set when a push overwrote the oldest entry.

## Operation
- Next-PC priority, evaluated every cycle:
  1. `reset`
  2. `stall`
  3. `branch`
  4. `ret`
  5. increment
- **Stall:** `pc`, RAS, `ras_count` and `ras_hit` hold. `branch`, `link` and `ret` are ignored; the requester holds them until the stall clears.
- **Branch:**
  - `pc <= pc + ({sign-extended offset to ADDR_W} << OFFSET_SHIFT)`, computed modulo 2^ADDR_W.
  - Bits shifted out above ADDR_W are discarded.
  - No `PC_INCR` bias is added.
- **Branch with link (`branch & link`):**
  - Also pushes `pc + PC_INCR` (modulo 2^ADDR_W) onto the RAS.
  - If `ras_count == RAS_DEPTH`, the push overwrites the oldest entry, `ras_count` stays at RAS_DEPTH, and `ras_ovf` sets.
- **`link` without `branch`:** no effect.
- **Return (`ret`, no `branch`):**
  - If `ras_count > 0`: `pc <= top entry`, pop, `ras_hit <= 1`.
  - Otherwise: `pc <= ret_addr`, `ras_hit <= 0`, and the RAS is unchanged.
- **`branch` and `ret` in the same cycle:** `branch` wins. The return is dropped, and the stack is not popped.
- **Increment (no request):** `pc <= pc + PC_INCR`, wrapping at 2^ADDR_W. `ras_hit <= 0`.
- **RAS storage:** circular, with a top-of-stack pointer. Push writes at `tos+1`; pop reads `tos` and then decrements it. Pointer arithmetic wraps modulo RAS_DEPTH.

## Timing
- Every output is registered. A request sampled at edge N is visible on `pc` after edge N (1-cycle latency).
- The RAS top entry is readable in the same cycle as the `ret` request. There is no extra bubble.
- **Reset values:** `pc = RESET_VEC`, `ras_count = 0`, `ras_ovf = 0`, `ras_hit = 0`. RAS contents are don't-care.
- **Reset mid-operation:** `reset` overrides every other input on that edge, and the pending push or pop is discarded.
- `ras_ovf` clears only on `reset`.

## Configuration
- Macro: `PC_UNIT_RAS_EN`.
- **Defined:** the RAS is built as described above.
- **Undefined:**
  - No RAS storage is instantiated.
  - `ret` always loads `ret_addr`.
  - `link` only qualifies `branch` and pushes nothing.
  - `ras_count`, `ras_hit` and `ras_ovf` are tied to 0.
  - All other behaviour is identical.

## Test plan
- **Reset, then free run:** assert `reset` with `RESET_VEC=0x100`, deassert, run 3 cycles → `pc` reads 0x100, 0x104, 0x108, 0x10C; all RAS outputs are 0.
- **Backward branch and wrap:**
  - At `pc=0x108`, `branch` with `offset=0xFFFFFE` → `pc=0x100`.
  - At `pc=0xFFFFFFFC` with no request → `pc=0x0`.
- **Call/return pair (RAS enabled):**
  - At `pc=0x200`, `branch`+`link` with `offset=0x10` → `pc=0x240`, `ras_count=1`.
  - Then `ret` with `ret_addr=0xDEAD` → `pc=0x204`, `ras_hit=1`, `ras_count=0`.
- **Overflow (`RAS_DEPTH=4`):** five calls from 0x0, 0x100, 0x200, 0x300, 0x400 → `ras_ovf=1`, `ras_count=4`. Then five returns → 0x404, 0x304, 0x204, 0x104, then `ret_addr` with `ras_hit=0`.
- **Stall and conflict:**
  - `stall` held 3 cycles with `branch` asserted → `pc` unchanged throughout, then the branch is taken on the first unstalled edge.
  - `branch` and `ret` together with one RAS entry → branch target taken, `ras_count` stays 1.
- **Macro undefined:** call from 0x200 then `ret` with `ret_addr=0x500` → `pc=0x500`; `ras_count`, `ras_hit` and `ras_ovf` are always 0.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit -- registered program counter for the fetch stage.
//
// Holds the PC in a register and picks the next value each cycle with priority
// reset > stall > branch > ret > sequential increment. Branch targets are
// pc + (sign-extended offset << OFFSET_SHIFT), modulo 2^ADDR_W. Calls
// (branch & link) push pc + PC_INCR onto a circular return-address stack;
// returns pop it, falling back to ret_addr when the stack is empty.
//
// Build option: define PC_UNIT_RAS_EN to build the return-address stack.
// Without it, ret always loads ret_addr, link pushes nothing, and
// ras_count / ras_hit / ras_ovf are tied to 0.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   stall      in   hold pc, RAS, ras_count and ras_hit; requests ignored
//   branch     in   take pc + (sext(offset) << OFFSET_SHIFT)
//   link       in   with branch: also push the return address
//   ret        in   take a return (RAS top, else ret_addr)
//   offset     in   [OFFSET_W-1:0] branch offset field
//   ret_addr   in   [ADDR_W-1:0] link-register value, fallback return target
//   pc         out  [ADDR_W-1:0] current PC
//   ras_hit    out  previous accepted cycle was a return served by the RAS
//   ras_count  out  [clog2(RAS_DEPTH):0] valid RAS entries
//   ras_ovf    out  sticky: a push overwrote the oldest entry

module pc_unit #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned OFFSET_W     = 24,
  parameter int unsigned OFFSET_SHIFT = 2,
  parameter int unsigned PC_INCR      = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         branch,
  input  logic                         link,
  input  logic                         ret,
  input  logic [OFFSET_W-1:0]          offset,
  input  logic [ADDR_W-1:0]            ret_addr,
  output logic [ADDR_W-1:0]            pc,
  output logic                         ras_hit,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] INCR = ADDR_W'(PC_INCR);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] off_ext;
  logic              ras_valid;
  logic [ADDR_W-1:0] ras_top;
  logic              take_pop;

  // Signed cast sign-extends the offset before it is widened to ADDR_W; the
  // shift then happens at ADDR_W so bits above the PC width fall away.
  assign off_ext = ADDR_W'($signed(offset));
  assign br_pc   = pc_q + (off_ext << OFFSET_SHIFT);
  assign seq_pc  = pc_q + INCR;

  // Branch wins over ret, so a simultaneous return never pops the stack.
  always_comb begin
    pc_nxt   = seq_pc;
    take_pop = 1'b0;
    if (branch) begin
      pc_nxt = br_pc;
    end else if (ret) begin
      if (ras_valid) begin
        pc_nxt   = ras_top;
        take_pop = 1'b1;
      end else begin
        pc_nxt = ret_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VEC;
    end else if (!stall) begin
      pc_q <= pc_nxt;
    end
  end

  assign pc = pc_q;

`ifdef PC_UNIT_RAS_EN

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  tos_q;
  logic [PTR_W-1:0]  tos_inc;
  logic [CNT_W-1:0]  cnt_q;
  logic              hit_q;
  logic              ovf_q;
  logic              do_push;
  logic              ras_full;

  assign tos_inc   = tos_q + PTR_W'(1);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_valid = (cnt_q != '0);
  assign ras_top   = ras_mem[tos_q];
  assign do_push   = !stall && branch && link;

  // When full, the push lands on the slot after tos, which is the oldest
  // entry in a circular stack, so overwrite needs no special addressing.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q <= '1;
      cnt_q <= '0;
      hit_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      // ras_hit is a per-cycle indication: only a RAS-served return sets it.
      hit_q <= take_pop;
      if (do_push) begin
        tos_q <= tos_inc;
        if (ras_full) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (take_pop) begin
        tos_q <= tos_q - PTR_W'(1);
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      ras_mem[tos_inc] <= seq_pc;
    end
  end

  assign ras_hit   = hit_q;
  assign ras_count = cnt_q;
  assign ras_ovf   = ovf_q;

`else

  logic unused_ras;

  assign ras_valid  = 1'b0;
  assign ras_top    = '0;
  assign unused_ras = take_pop | link;
  assign ras_hit    = 1'b0;
  assign ras_count  = '0;
  assign ras_ovf    = 1'b0;

`endif

endmodule

// File: tb/tb_pc_unit.sv
`timescale 1ns/1ps
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  localparam int OW = 24;

  logic        clk = 1'b0;
  logic        reset, stall, branch, link, ret;
  logic [23:0] offset;
  logic [31:0] ret_addr;
  logic [31:0] pc;
  logic        ras_hit;
  logic [2:0]  ras_count;
  logic        ras_ovf;

  always #5 clk = ~clk;

  pc_unit #(
    .ADDR_W(32), .OFFSET_W(24), .OFFSET_SHIFT(2), .PC_INCR(4),
    .RESET_VEC(32'h100), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .link(link),
    .ret(ret), .offset(offset), .ret_addr(ret_addr), .pc(pc),
    .ras_hit(ras_hit), .ras_count(ras_count), .ras_ovf(ras_ovf)
  );

  int nchk = 0;
  int nerr = 0;

  // Reference model: PC as an integer, RAS as a bounded queue (oldest at front).
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_hit;
  logic        m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic lk, input logic rt,
                       input logic [23:0] off, input logic [31:0] ra);
    stall = st; branch = br; link = lk; ret = rt; offset = off; ret_addr = ra;
  endtask

  task automatic tick();
    longint      off;
    logic [31:0] link_pc;
    if (reset) begin
      m_pc = 32'h100;
      m_ras.delete();
      m_hit = 1'b0;
      m_ovf = 1'b0;
    end else if (!stall) begin
      if (branch) begin
        off = longint'(offset);
        if (offset[OW-1]) off = off - (longint'(1) << OW);
        link_pc = m_pc + 32'd4;
        m_pc = 32'(longint'(m_pc) + off * 4);
        if (link && RAS_ON) begin
          m_ras.push_back(link_pc);
          if (m_ras.size() > 4) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
        end
        m_hit = 1'b0;
      end else if (ret && RAS_ON && m_ras.size() > 0) begin
        m_pc  = m_ras.pop_back();
        m_hit = 1'b1;
      end else if (ret) begin
        m_pc  = ret_addr;
        m_hit = 1'b0;
      end else begin
        m_pc  = m_pc + 32'd4;
        m_hit = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("model pc", pc, m_pc);
    chk("model ras_count", 32'(ras_count), 32'(m_ras.size()));
    chk("model ras_hit", 32'(ras_hit), 32'(m_hit));
    chk("model ras_ovf", 32'(ras_ovf), 32'(m_ovf));
  endtask

  typedef struct {
    logic        st, br, lk, rt;
    logic [23:0] off;
    logic [31:0] ra;
    logic [31:0] pc_r;   // expected pc with the RAS built
    logic [31:0] pc_n;   // expected pc without the RAS
    logic [2:0]  cnt;    // expected ras_count with the RAS built
    logic        hit;    // expected ras_hit with the RAS built
  } vec_t;

  vec_t vt[$];

  initial begin
    // Starts from pc = 0x100 with an empty stack.
    vt.push_back('{0,0,0,0, 24'h0,      32'h0,    32'h104,  32'h104,  3'd0, 1'b0});
    vt.push_back('{0,0,0,0, 24'h0,      32'h0,    32'h108,  32'h108,  3'd0, 1'b0});
    vt.push_back('{0,0,0,0, 24'h0,      32'h0,    32'h10C,  32'h10C,  3'd0, 1'b0});
    vt.push_back('{0,1,0,0, 24'hFFFFFF, 32'h0,    32'h108,  32'h108,  3'd0, 1'b0});
    vt.push_back('{0,1,0,0, 24'hFFFFFE, 32'h0,    32'h100,  32'h100,  3'd0, 1'b0});
    vt.push_back('{0,1,0,0, 24'h40,     32'h0,    32'h200,  32'h200,  3'd0, 1'b0});
    vt.push_back('{0,1,1,0, 24'h10,     32'h0,    32'h240,  32'h240,  3'd1, 1'b0});
    vt.push_back('{0,0,0,1, 24'h0,      32'hDEAD, 32'h204,  32'hDEAD, 3'd0, 1'b1});
    vt.push_back('{1,0,0,0, 24'h0,      32'hDEAD, 32'h204,  32'hDEAD, 3'd0, 1'b1});
    vt.push_back('{0,0,0,1, 24'h0,      32'h1000, 32'h1000, 32'h1000, 3'd0, 1'b0});
    vt.push_back('{0,1,1,0, 24'h4,      32'h0,    32'h1010, 32'h1010, 3'd1, 1'b0});
    vt.push_back('{0,1,0,1, 24'h8,      32'h3000, 32'h1030, 32'h1030, 3'd1, 1'b0});
    vt.push_back('{0,0,0,1, 24'h0,      32'h3000, 32'h1004, 32'h3000, 3'd0, 1'b1});
    vt.push_back('{0,0,0,1, 24'h0,      32'h2000, 32'h2000, 32'h2000, 3'd0, 1'b0});
    vt.push_back('{0,0,1,0, 24'h5,      32'h0,    32'h2004, 32'h2004, 3'd0, 1'b0});
    vt.push_back('{1,1,0,0, 24'h1,      32'h0,    32'h2004, 32'h2004, 3'd0, 1'b0});
    vt.push_back('{1,0,0,1, 24'h0,      32'h5000, 32'h2004, 32'h2004, 3'd0, 1'b0});
    vt.push_back('{0,0,0,0, 24'h0,      32'h0,    32'h2008, 32'h2008, 3'd0, 1'b0});

    reset = 1'b1;
    drive(0, 0, 0, 0, 24'h0, 32'h0);
    tick();
    tick();
    chk("reset pc", pc, 32'h100);
    chk("reset ras_count", 32'(ras_count), 32'd0);
    chk("reset ras_hit", 32'(ras_hit), 32'd0);
    chk("reset ras_ovf", 32'(ras_ovf), 32'd0);
    reset = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].st, vt[i].br, vt[i].lk, vt[i].rt, vt[i].off, vt[i].ra);
      tick();
      chk($sformatf("vec%0d pc", i), pc, RAS_ON ? vt[i].pc_r : vt[i].pc_n);
      chk($sformatf("vec%0d ras_count", i), 32'(ras_count), RAS_ON ? 32'(vt[i].cnt) : 32'd0);
      chk($sformatf("vec%0d ras_hit", i), 32'(ras_hit), RAS_ON ? 32'(vt[i].hit) : 32'd0);
    end

    // Overflow: five calls from 0x0..0x400, then five returns.
    reset = 1'b1;
    drive(0, 0, 0, 0, 24'h0, 32'h0);
    tick();
    reset = 1'b0;
    drive(0, 1, 0, 0, 24'hFFFFC0, 32'h0);
    tick();
    chk("ovf start pc", pc, 32'h0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 0, 24'h40, 32'h0);
      tick();
      chk($sformatf("call%0d pc", k), pc, 32'((k + 1) * 32'h100));
    end
    chk("ovf flag", 32'(ras_ovf), 32'(RAS_ON));
    chk("ovf count", 32'(ras_count), RAS_ON ? 32'd4 : 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 24'h0, 32'h800);
      tick();
      chk($sformatf("ret%0d pc", k), pc, RAS_ON ? 32'(32'h404 - k * 32'h100) : 32'h800);
      chk($sformatf("ret%0d hit", k), 32'(ras_hit), 32'(RAS_ON));
    end
    drive(0, 0, 0, 1, 24'h0, 32'h800);
    tick();
    chk("ret4 pc", pc, 32'h800);
    chk("ret4 hit", 32'(ras_hit), 32'd0);
    chk("ret4 count", 32'(ras_count), 32'd0);
    chk("ovf sticky", 32'(ras_ovf), 32'(RAS_ON));

    // Stall held three cycles with a pending branch.
    drive(1, 1, 0, 0, 24'h10, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d pc", k), pc, 32'h800);
    end
    stall = 1'b0;
    tick();
    chk("post-stall branch pc", pc, 32'h840);

    // Wrap at 2^32, and ras_ovf cleared by reset.
    reset = 1'b1;
    drive(0, 0, 0, 0, 24'h0, 32'h0);
    tick();
    chk("ovf cleared", 32'(ras_ovf), 32'd0);
    reset = 1'b0;
    drive(0, 1, 0, 0, 24'hFFFFBF, 32'h0);
    tick();
    chk("pre-wrap pc", pc, 32'hFFFFFFFC);
    drive(0, 0, 0, 0, 24'h0, 32'h0);
    tick();
    chk("wrap pc", pc, 32'h0);

    // Randomized traffic against the model, including mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 63) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      branch = ($urandom_range(0, 3) == 0);
      link   = $urandom_range(0, 1) == 1;
      ret    = ($urandom_range(0, 2) == 0);
      offset = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($signed(8'($urandom)));
      ret_addr = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
